mem_access_unit: RTL and testbench

Data-memory access unit for the MEM pipeline stage. Sits between the EX/MEM stage register and the MEM/WB stage register. Takes the load/store command and the effective address, and runs a request/acknowledge transaction on the data-memory bus. It aligns store data and byte enables, sign- or zero-extends load data, and stalls the pipeline until the bus transaction finishes. Its `MemReadData` and `MemStall` outputs feed the MEM/WB register.

---
 rtl/mem_access_unit.sv | 169 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: big-endian lane steering, req/ack bus handshake, load extension.
// Optional misalignment exception enabled by defining MEM_ALIGN_EXC_EN (adds the AddrErr port).
module mem_access_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        MemSize,
  input  logic              MemSigned,
  input  logic [ADDR_W-1:0] ALUResult,
  input  logic [31:0]       StoreData,
  input  logic              Flush,
  output logic              DReq,
  output logic              DWe,
  output logic [ADDR_W-1:0] DAddr,
  output logic [3:0]        DBe,
  output logic [31:0]       DWData,
  input  logic              DAck,
  input  logic [31:0]       DRData,
  output logic [31:0]       MemReadData,
`ifdef MEM_ALIGN_EXC_EN
  output logic              MemStall,
  output logic              AddrErr
`else
  output logic              MemStall
`endif
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic        size_byte, size_half;
  logic        access_req, misaligned, access_valid;
  logic        start, ack_take;
  logic [1:0]  offset;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [1:0]  off_q;
  logic        byte_q, half_q, signed_q;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext;

  assign size_byte  = (MemSize == 2'b00);
  assign size_half  = (MemSize == 2'b01);
  assign access_req = (MemRead | MemWrite) & ~Flush;

`ifdef MEM_ALIGN_EXC_EN
  assign misaligned = (size_half & ALUResult[0]) |
                      (~size_byte & ~size_half & (ALUResult[1:0] != 2'b00));
  assign AddrErr    = (state_q == StIdle) & access_req & misaligned;
`else
  assign misaligned = 1'b0;
`endif

  assign access_valid = access_req & ~misaligned;

  // Low address bits are dropped to the natural alignment of the access size.
  always_comb begin
    if (size_byte) begin
      offset = ALUResult[1:0];
    end else if (size_half) begin
      offset = {ALUResult[1], 1'b0};
    end else begin
      offset = 2'b00;
    end
  end

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = StoreData;
    if (size_byte) begin
      be_d    = 4'b1000 >> offset;
      wdata_d = {4{StoreData[7:0]}};
    end else if (size_half) begin
      be_d    = offset[1] ? 4'b0011 : 4'b1100;
      wdata_d = {2{StoreData[15:0]}};
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // MemStall depends only on state and request inputs, never on DAck.
  always_comb begin
    state_d  = state_q;
    MemStall = 1'b0;
    start    = 1'b0;
    ack_take = 1'b0;
    case (state_q)
      StIdle: begin
        if (access_valid) begin
          MemStall = 1'b1;
          start    = 1'b1;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        MemStall = 1'b1;
        if (DAck) begin
          ack_take = 1'b1;
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Offset 0 is the most significant lane on this big-endian bus.
  always_comb begin
    case (off_q)
      2'd0:    load_byte = DRData[31:24];
      2'd1:    load_byte = DRData[23:16];
      2'd2:    load_byte = DRData[15:8];
      default: load_byte = DRData[7:0];
    endcase
    load_half = off_q[1] ? DRData[15:0] : DRData[31:16];
    if (byte_q) begin
      load_ext = {{24{signed_q & load_byte[7]}}, load_byte};
    end else if (half_q) begin
      load_ext = {{16{signed_q & load_half[15]}}, load_half};
    end else begin
      load_ext = DRData;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      DReq        <= 1'b0;
      DWe         <= 1'b0;
      DAddr       <= '0;
      DBe         <= 4'b0000;
      DWData      <= 32'h0;
      MemReadData <= 32'h0;
      off_q       <= 2'b00;
      byte_q      <= 1'b0;
      half_q      <= 1'b0;
      signed_q    <= 1'b0;
    end else if (start) begin
      DReq     <= 1'b1;
      DWe      <= MemWrite;
      DAddr    <= {ALUResult[ADDR_W-1:2], 2'b00};
      DBe      <= be_d;
      DWData   <= wdata_d;
      off_q    <= offset;
      byte_q   <= size_byte;
      half_q   <= size_half;
      signed_q <= MemSigned;
    end else if (ack_take) begin
      DReq <= 1'b0;
      if (!DWe) begin
        MemReadData <= load_ext;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: driver pushes expected bus/load results, monitor compares.
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        MemRead = 1'b0, MemWrite = 1'b0, MemSigned = 1'b0, Flush = 1'b0;
  logic [1:0]  MemSize = 2'b00;
  logic [31:0] ALUResult = 32'h0, StoreData = 32'h0;
  logic        DReq, DWe, DAck, MemStall;
  logic [31:0] DAddr, DWData, DRData, MemReadData;
  logic [3:0]  DBe;
`ifdef MEM_ALIGN_EXC_EN
  logic        AddrErr;
`endif

  mem_access_unit #(.ADDR_W(32)) dut (
    .CLK(CLK), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize),
    .MemSigned(MemSigned), .ALUResult(ALUResult), .StoreData(StoreData), .Flush(Flush),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DBe(DBe), .DWData(DWData), .DAck(DAck),
    .DRData(DRData), .MemReadData(MemReadData),
`ifdef MEM_ALIGN_EXC_EN
    .MemStall(MemStall), .AddrErr(AddrErr)
`else
    .MemStall(MemStall)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;
  typedef struct {
    bit          is_rd;
    logic [31:0] val;
  } rd_t;

  bus_t        exp_bus[$];
  rd_t         exp_rd[$];
  logic [31:0] mem_model = 32'h0;
  int          vectors = 0, miscompares = 0;
  int          slave_wait = 0;
  logic [31:0] slave_rdata = 32'h0;
  bit          spurious_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus slave: acks after slave_wait wait cycles; may pulse stray acks while no request is up.
  initial begin
    int wcnt;
    wcnt   = 0;
    DAck   = 1'b0;
    DRData = 32'h0;
    forever begin
      @(posedge CLK);
      #1;
      if (DReq) begin
        DAck   = (wcnt == slave_wait);
        DRData = (wcnt == slave_wait) ? slave_rdata : $urandom;
        wcnt++;
      end else begin
        wcnt   = 0;
        DAck   = spurious_en && ($urandom_range(0, 3) == 0);
        DRData = $urandom;
      end
    end
  end

  // Monitor: compares bus requests on DReq rise and load data in the cycle after the ack.
  bit dreq_prev = 1'b0;
  bit ack_seen  = 1'b0;
  always @(negedge CLK) begin : monitor
    bus_t b;
    rd_t  r;
    if (RST) begin
      if (ack_seen) begin
        if (exp_rd.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_ack: got ack with no pending transaction, expected none");
        end else begin
          r = exp_rd.pop_front();
          if (r.is_rd) mem_model = r.val;
          check("load_data", MemReadData, mem_model);
        end
      end
      if (DReq && !dreq_prev) begin
        if (exp_bus.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_req: got DReq addr %h, expected no request", DAddr);
        end else begin
          b = exp_bus.pop_front();
          check("req_we", {31'h0, DWe}, {31'h0, b.we});
          check("req_addr", DAddr, b.addr);
          check("req_be", {28'h0, DBe}, {28'h0, b.be});
          check("req_wdata", DWData, b.wdata);
          check("rdata_hold", MemReadData, mem_model);
        end
      end
      ack_seen = DReq && DAck;
    end else begin
      ack_seen = 1'b0;
    end
    dreq_prev = DReq;
  end

  function automatic bus_t model_bus(input bit wr, input logic [1:0] sz, input logic [31:0] addr,
                                     input logic [31:0] sd);
    bus_t b;
    int nb, eoff;
    nb   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    eoff = (nb == 1) ? int'(addr[1:0]) : (nb == 2) ? 2 * int'(addr[1]) : 0;
    b.we   = wr;
    b.addr = addr & 32'hFFFF_FFFC;
    b.be   = 4'b0000;
    for (int k = 0; k < nb; k++) b.be[3 - (eoff + k)] = 1'b1;
    case (nb)
      1:       b.wdata = {4{sd[7:0]}};
      2:       b.wdata = {2{sd[15:0]}};
      default: b.wdata = sd;
    endcase
    return b;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input bit sg,
                                             input logic [31:0] addr, input logic [31:0] rdata);
    logic [31:0] raw, mask;
    int nb, eoff;
    nb   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    eoff = (nb == 1) ? int'(addr[1:0]) : (nb == 2) ? 2 * int'(addr[1]) : 0;
    raw  = rdata >> (8 * (4 - eoff - nb));
    if (nb < 4) begin
      mask = (32'h1 << (8 * nb)) - 32'h1;
      raw  = raw & mask;
      if (sg && raw[8 * nb - 1]) raw = raw | ~mask;
    end
    return raw;
  endfunction

  // Called at posedge+1; returns at posedge+1 of the cycle after DONE.
  task automatic do_access(input bit rd, input bit wr, input logic [1:0] sz, input bit sg,
                           input logic [31:0] addr, input logic [31:0] sd,
                           input logic [31:0] rdata, input int w, input bit flush_mid);
    rd_t r;
    int  cnt;
    bit  done;
    r.is_rd = !wr;
    r.val   = model_load(sz, sg, addr, rdata);
    exp_bus.push_back(model_bus(wr, sz, addr, sd));
    exp_rd.push_back(r);
    slave_wait  = w;
    slave_rdata = rdata;
    MemRead = rd; MemWrite = wr; MemSize = sz; MemSigned = sg;
    ALUResult = addr; StoreData = sd; Flush = 1'b0;
    cnt  = 0;
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge CLK);
      if (MemStall) cnt++;
      else done = 1'b1;
      if (!done) begin
        @(posedge CLK);
        #1;
        if (flush_mid) Flush = 1'b1;
      end
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL stall_timeout: got MemStall stuck high, expected release within 64 cycles");
    end
    @(posedge CLK);
    #1;
    MemRead = 1'b0; MemWrite = 1'b0; Flush = 1'b0;
    check("stall_cycles", cnt, w + 2);
  endtask

  initial begin
    bus_t        b;
    logic [1:0]  sz;
    logic [31:0] addr;
    int          op;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(negedge CLK);
    check("rst_dreq", {31'h0, DReq}, 32'h0);
    check("rst_stall", {31'h0, MemStall}, 32'h0);
    check("rst_rdata", MemReadData, 32'h0);
    check("rst_dwe", {31'h0, DWe}, 32'h0);
    check("rst_daddr", DAddr, 32'h0);
    check("rst_dbe", {28'h0, DBe}, 32'h0);
    check("rst_dwdata", DWData, 32'h0);
    @(posedge CLK);
    #1;

    // LB at 0x1003, ack in first busy cycle
    do_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h1003, 32'h0, 32'h0000_00F0, 0, 1'b0);
    check("lb_result", MemReadData, 32'hFFFF_FFF0);
    // SH at 0x2002 with three wait cycles; store must not touch MemReadData
    do_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h2002, 32'h1234_ABCD, 32'h5555_AAAA, 3, 1'b0);
    check("sh_keeps_rdata", MemReadData, 32'hFFFF_FFF0);
    // LW with Flush raised during BUSY: transaction completes normally
    do_access(1'b1, 1'b0, 2'b11, 1'b0, 32'h4000, 32'h0, 32'hCAFE_BABE, 2, 1'b1);
    check("flush_busy_rdata", MemReadData, 32'hCAFE_BABE);

    // Flush in IDLE: nothing starts
    MemRead = 1'b1; MemSize = 2'b11; ALUResult = 32'h5000; Flush = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      check("flush_idle_stall", {31'h0, MemStall}, 32'h0);
      check("flush_idle_dreq", {31'h0, DReq}, 32'h0);
    end
    @(posedge CLK);
    #1;
    MemRead = 1'b0; Flush = 1'b0;

`ifdef MEM_ALIGN_EXC_EN
    MemRead = 1'b1; MemSize = 2'b11; ALUResult = 32'h3002;
    @(negedge CLK);
    check("misalign_err", {31'h0, AddrErr}, 32'h1);
    check("misalign_stall", {31'h0, MemStall}, 32'h0);
    @(posedge CLK);
    #1;
    MemRead = 1'b0;
    @(negedge CLK);
    check("misalign_dreq", {31'h0, DReq}, 32'h0);
    check("misalign_err_clr", {31'h0, AddrErr}, 32'h0);
    @(posedge CLK);
    #1;
`else
    do_access(1'b1, 1'b0, 2'b11, 1'b0, 32'h3002, 32'h0, 32'h0BAD_F00D, 1, 1'b0);
    check("forced_align_rdata", MemReadData, 32'h0BAD_F00D);
`endif

    // Asynchronous reset in the middle of BUSY
    b.we = 1'b0; b.addr = 32'h6000; b.be = 4'b1111; b.wdata = 32'h0;
    exp_bus.push_back(b);
    slave_wait = 10;
    MemRead = 1'b1; MemSize = 2'b11; ALUResult = 32'h6000; StoreData = 32'h0;
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #3;
    RST = 1'b0;
    #1;
    check("async_dreq", {31'h0, DReq}, 32'h0);
    MemRead = 1'b0;
    mem_model = 32'h0;
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(negedge CLK);
    check("post_rst_stall", {31'h0, MemStall}, 32'h0);
    check("post_rst_rdata", MemReadData, 32'h0);
    @(negedge CLK);
    check("no_done_dreq", {31'h0, DReq}, 32'h0);
    @(posedge CLK);
    #1;

    spurious_en = 1'b1;
    for (int n = 0; n < 150; n++) begin
      op   = $urandom_range(0, 2);
      sz   = 2'($urandom_range(0, 3));
      addr = $urandom;
`ifdef MEM_ALIGN_EXC_EN
      if (sz == 2'b01) addr[0] = 1'b0;
      else if (sz != 2'b00) addr[1:0] = 2'b00;
`endif
      do_access(op != 1, op != 0, sz, 1'($urandom_range(0, 1)), addr, $urandom, $urandom,
                $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge CLK);
        #1;
      end
    end
    spurious_en = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("bus_queue_drained", exp_bus.size(), 32'h0);
    check("rd_queue_drained", exp_rd.size(), 32'h0);
    check("final_rdata", MemReadData, mem_model);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
